// File: rtl/adpll_ctrl_pkg.sv
// Shared constants for the NetworkADPLL array controllers.
package adpll_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STAGGER = 2'd1,
      ST_ACQUIRE = 2'd2,
      ST_TRACK   = 2'd3
   } state_e;

   // Default loop gains, also used by the array top-level.
   localparam logic [5:0] DEF_KP_ACQ = 6'd8;
   localparam logic [8:0] DEF_KI_ACQ = 9'd8;
   localparam logic [5:0] DEF_KP_TRK = 6'd4;
   localparam logic [8:0] DEF_KI_TRK = 9'd1;

   // Bit positions of each node in the enable vector.
   localparam int unsigned NODE_11 = 0;
   localparam int unsigned NODE_12 = 1;
   localparam int unsigned NODE_21 = 2;
   localparam int unsigned NODE_22 = 3;

endpackage

// File: rtl/adpll_err_window.sv
// Reference edge strobe plus lock/unlock window flags on |error|, one register stage.
module adpll_err_window #(
   parameter int unsigned PDET_WIDTH    = 8,
   parameter int unsigned LOCK_THRESH   = 4,
   parameter int unsigned UNLOCK_THRESH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ref_i,
   input  logic [PDET_WIDTH-1:0] error_i,
   output logic                  ref_edge_o,
   output logic                  in_win_o,
   output logic                  out_win_o
);

   localparam logic [PDET_WIDTH-1:0] ERR_MIN = {1'b1, {(PDET_WIDTH-1){1'b0}}};
   localparam logic [PDET_WIDTH-1:0] ERR_MAX = {1'b0, {(PDET_WIDTH-1){1'b1}}};

   logic                  ref_q;
   logic [PDET_WIDTH-1:0] mag;

   // Saturating magnitude: the most negative code maps to the largest positive one.
   always_comb begin
      mag = error_i;
      if (error_i[PDET_WIDTH-1]) begin
         if (error_i == ERR_MIN) mag = ERR_MAX;
         else                    mag = PDET_WIDTH'(-error_i);
      end
   end

   // Register the reference history, the edge strobe and the window flags together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_q      <= 1'b0;
         ref_edge_o <= 1'b0;
         in_win_o   <= 1'b0;
         out_win_o  <= 1'b0;
      end else begin
         ref_q      <= ref_i;
         ref_edge_o <= ref_i & ~ref_q;
         in_win_o   <= (mag <= PDET_WIDTH'(LOCK_THRESH));
         out_win_o  <= (mag >  PDET_WIDTH'(UNLOCK_THRESH));
      end
   end

endmodule

// File: rtl/adpll_gear_ctrl.sv
// Staggered start-up and acquire/track gain scheduling for the 2x2 ADPLL array.
module adpll_gear_ctrl
   import adpll_ctrl_pkg::*;
#(
   parameter int unsigned         PDET_WIDTH    = 8,
   parameter int unsigned         KP_WIDTH      = 6,
   parameter int unsigned         KI_WIDTH      = 9,
   parameter logic [KP_WIDTH-1:0] KP_ACQ        = KP_WIDTH'(DEF_KP_ACQ),
   parameter logic [KI_WIDTH-1:0] KI_ACQ        = KI_WIDTH'(DEF_KI_ACQ),
   parameter logic [KP_WIDTH-1:0] KP_TRK        = KP_WIDTH'(DEF_KP_TRK),
   parameter logic [KI_WIDTH-1:0] KI_TRK        = KI_WIDTH'(DEF_KI_TRK),
   parameter int unsigned         STAGGER_EDGES = 8,
   parameter int unsigned         LOCK_THRESH   = 4,
   parameter int unsigned         LOCK_COUNT    = 16,
   parameter int unsigned         UNLOCK_THRESH = 16,
   parameter int unsigned         UNLOCK_COUNT  = 4,
   parameter int unsigned         CNT_WIDTH     = 8
) (
   input  logic                  fpga_clk_i,
   input  logic                  reset_i,
   input  logic                  enable_i,
   input  logic                  ref_i,
   input  logic [PDET_WIDTH-1:0] error_i,
   input  logic                  gain_override_i,
   input  logic [KP_WIDTH-1:0]   kp_man_i,
   input  logic [KI_WIDTH-1:0]   ki_man_i,
   output logic [3:0]            node_enable_o,
   output logic [KP_WIDTH-1:0]   kp_o,
   output logic [KI_WIDTH-1:0]   ki_o,
   output logic                  locked_o,
   output logic [1:0]            state_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] STG_LAST    = CNT_WIDTH'(STAGGER_EDGES - 1);
   localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);

   state_e               state_q, state_d;
   logic [3:0]           node_en_d;
   logic [CNT_WIDTH-1:0] stg_cnt_q, stg_cnt_d;
   logic [CNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
   logic [CNT_WIDTH-1:0] unlock_cnt_q, unlock_cnt_d;
   logic [KP_WIDTH-1:0]  kp_d;
   logic [KI_WIDTH-1:0]  ki_d;
   logic                 ref_edge, in_win, out_win;

   adpll_err_window #(
      .PDET_WIDTH    (PDET_WIDTH),
      .LOCK_THRESH   (LOCK_THRESH),
      .UNLOCK_THRESH (UNLOCK_THRESH)
   ) u_err_window (
      .clk        (fpga_clk_i),
      .rst        (reset_i),
      .ref_i      (ref_i),
      .error_i    (error_i),
      .ref_edge_o (ref_edge),
      .in_win_o   (in_win),
      .out_win_o  (out_win)
   );

   // State, counter and output registers.
   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         stg_cnt_q     <= '0;
         lock_cnt_q    <= '0;
         unlock_cnt_q  <= '0;
         node_enable_o <= '0;
         kp_o          <= KP_ACQ;
         ki_o          <= KI_ACQ;
         locked_o      <= 1'b0;
      end else begin
         state_q       <= state_d;
         stg_cnt_q     <= stg_cnt_d;
         lock_cnt_q    <= lock_cnt_d;
         unlock_cnt_q  <= unlock_cnt_d;
         node_enable_o <= node_en_d;
         kp_o          <= kp_d;
         ki_o          <= ki_d;
         locked_o      <= (state_d == ST_TRACK);
      end
   end

   assign state_o = state_q;

   // Next-state, counter and gain selection; a dropped enable beats any edge.
   always_comb begin
      state_d      = state_q;
      node_en_d    = node_enable_o;
      stg_cnt_d    = stg_cnt_q;
      lock_cnt_d   = lock_cnt_q;
      unlock_cnt_d = unlock_cnt_q;

      if (!enable_i) begin
         state_d      = ST_IDLE;
         node_en_d    = '0;
         stg_cnt_d    = '0;
         lock_cnt_d   = '0;
         unlock_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d            = ST_STAGGER;
               node_en_d          = '0;
               node_en_d[NODE_11] = 1'b1;
               stg_cnt_d          = '0;
               lock_cnt_d         = '0;
               unlock_cnt_d       = '0;
            end
            ST_STAGGER: begin
               if (ref_edge) begin
                  if (stg_cnt_q == STG_LAST) begin
                     stg_cnt_d = '0;
                     if (node_enable_o[NODE_22]) state_d   = ST_ACQUIRE;
                     else                        node_en_d = {node_enable_o[2:0], 1'b1};
                  end else begin
                     stg_cnt_d = stg_cnt_q + CNT_ONE;
                  end
               end
            end
            ST_ACQUIRE: begin
               if (ref_edge) begin
                  if (!in_win) begin
                     lock_cnt_d = '0;
                  end else if (lock_cnt_q >= LOCK_LAST) begin
                     state_d    = ST_TRACK;
                     lock_cnt_d = '0;
                  end else begin
                     lock_cnt_d = lock_cnt_q + CNT_ONE;
                  end
               end
            end
            ST_TRACK: begin
               if (ref_edge) begin
                  if (!out_win) begin
                     unlock_cnt_d = '0;
                  end else if (unlock_cnt_q >= UNLOCK_LAST) begin
                     state_d      = ST_ACQUIRE;
                     lock_cnt_d   = '0;
                     unlock_cnt_d = '0;
                  end else begin
                     unlock_cnt_d = unlock_cnt_q + CNT_ONE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      kp_d = (state_d == ST_TRACK) ? KP_TRK : KP_ACQ;
      ki_d = (state_d == ST_TRACK) ? KI_TRK : KI_ACQ;
      if (gain_override_i) begin
         kp_d = kp_man_i;
         ki_d = ki_man_i;
      end
   end

endmodule
